// File: rtl/countdown_timer_hms_pkg.sv
// Shared state/select codes and field limits for the hh:mm:ss countdown timer.
package countdown_timer_hms_pkg;

  typedef enum logic [2:0] {
    ST_SET   = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_SEC  = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_HOUR = 2'd3
  } sel_t;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/countdown_timer_hms_if.sv
// Button inputs and display/status outputs of the countdown timer.
interface countdown_timer_hms_if
  import countdown_timer_hms_pkg::*;
#(
  parameter int HOUR_W = 5
);
  logic              stc;
  logic              inc;
  logic              dec;
  logic              run;
  logic [HOUR_W-1:0] hh;
  logic [5:0]        mm;
  logic [5:0]        ss;
  sel_t              sel;
  state_t            state;
  logic              blk;
  logic              done;
  logic              alarm;

  modport master (
    output stc, inc, dec, run,
    input  hh, mm, ss, sel, state, blk, done, alarm
  );

  modport slave (
    input  stc, inc, dec, run,
    output hh, mm, ss, sel, state, blk, done, alarm
  );
endinterface

// File: rtl/countdown_timer_hms_btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for one raw button level.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // synchronise the pin, then keep one more delayed copy to find the rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign pulse = sync_p1 & ~prev_p2;
endmodule

// File: rtl/countdown_timer_hms.sv
// hh:mm:ss countdown timer: button arbitration, FSM, 1 s prescaler and borrow decrement.
module countdown_timer_hms
  import countdown_timer_hms_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int MAX_HOURS = 23,
  parameter int HOUR_W    = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  countdown_timer_hms_if.slave bus
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]     PRE_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0]     PRE_HALF = PW'(CLK_HZ / 2);
  localparam logic [HOUR_W-1:0] HR_MAX   = HOUR_W'(MAX_HOURS);

  function automatic logic [5:0] inc6(input logic [5:0] v, input logic [5:0] top);
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] dec6(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  function automatic logic [HOUR_W-1:0] inc_hr(input logic [HOUR_W-1:0] v);
    return (v == HR_MAX) ? '0 : v + HOUR_W'(1);
  endfunction

  function automatic logic [HOUR_W-1:0] dec_hr(input logic [HOUR_W-1:0] v);
    return (v == '0) ? HR_MAX : v - HOUR_W'(1);
  endfunction

  function automatic sel_t next_sel(input sel_t s);
    case (s)
      SEL_NONE: return SEL_SEC;
      SEL_SEC:  return SEL_MIN;
      SEL_MIN:  return SEL_HOUR;
      default:  return SEL_NONE;
    endcase
  endfunction

  logic p_stc, p_inc, p_dec, p_run;
  logic ev_stc, ev_inc, ev_dec, ev_run;
  state_t state_q, state_d;
  sel_t sel_q;
  logic [HOUR_W-1:0] hh_q, hh_dn;
  logic [5:0] mm_q, mm_dn, ss_q, ss_dn;
  logic [PW-1:0] presc_q;
  logic done_q, alarm_q, blk_done_q, blk;
  logic time_zero, dn_zero, pre_wrap, tick;

  btn_edge u_stc (.clk(clk), .rst_n(rst_n), .d(bus.stc), .pulse(p_stc));
  btn_edge u_inc (.clk(clk), .rst_n(rst_n), .d(bus.inc), .pulse(p_inc));
  btn_edge u_dec (.clk(clk), .rst_n(rst_n), .d(bus.dec), .pulse(p_dec));
  btn_edge u_run (.clk(clk), .rst_n(rst_n), .d(bus.run), .pulse(p_run));

  // one event per cycle: stc beats inc beats dec beats run
  assign ev_stc = p_stc;
  assign ev_inc = p_inc & ~p_stc;
  assign ev_dec = p_dec & ~p_stc & ~p_inc;
  assign ev_run = p_run & ~p_stc & ~p_inc & ~p_dec;

  assign time_zero = (hh_q == '0) && (mm_q == 6'd0) && (ss_q == 6'd0);
  assign pre_wrap  = (presc_q == PRE_MAX);
  // a pause press holds the prescaler, so no tick can land on that cycle
  assign tick      = (state_q == ST_RUN) && pre_wrap && !ev_run;

  // borrow-correct one-second decrement of the current time
  always_comb begin
    ss_dn = ss_q;
    mm_dn = mm_q;
    hh_dn = hh_q;
    if (ss_q != 6'd0) begin
      ss_dn = ss_q - 6'd1;
    end else if (mm_q != 6'd0) begin
      ss_dn = SEC_MAX;
      mm_dn = mm_q - 6'd1;
    end else if (hh_q != '0) begin
      ss_dn = SEC_MAX;
      mm_dn = MIN_MAX;
      hh_dn = hh_q - HOUR_W'(1);
    end
  end

  assign dn_zero = (hh_dn == '0) && (mm_dn == 6'd0) && (ss_dn == 6'd0);

  // next-state selection and blink indicator
  always_comb begin
    state_d = state_q;
    blk     = 1'b1;
    case (state_q)
      ST_SET: begin
        if (ev_run && (sel_q == SEL_NONE) && !time_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        blk = (presc_q < PRE_HALF);
        if (ev_run) state_d = ST_PAUSE;
        else if (tick && dn_zero) state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (ev_run) state_d = ST_RUN;
        else if (ev_stc) state_d = ST_SET;
      end
      ST_DONE: begin
        blk = blk_done_q;
        if (ev_run) state_d = ST_SET;
      end
      default: state_d = ST_SET;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SET;
    else        state_q <= state_d;
  end

  // time fields, selection, prescaler and alarm bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= SEL_NONE;
      hh_q       <= '0;
      mm_q       <= 6'd0;
      ss_q       <= 6'd0;
      presc_q    <= '0;
      done_q     <= 1'b0;
      alarm_q    <= 1'b0;
      blk_done_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_SET: begin
          if (ev_stc) begin
            sel_q <= next_sel(sel_q);
          end else if (ev_inc) begin
            case (sel_q)
              SEL_SEC:  ss_q <= inc6(ss_q, SEC_MAX);
              SEL_MIN:  mm_q <= inc6(mm_q, MIN_MAX);
              SEL_HOUR: hh_q <= inc_hr(hh_q);
              default:  ;
            endcase
          end else if (ev_dec) begin
            case (sel_q)
              SEL_SEC:  ss_q <= dec6(ss_q, SEC_MAX);
              SEL_MIN:  mm_q <= dec6(mm_q, MIN_MAX);
              SEL_HOUR: hh_q <= dec_hr(hh_q);
              default:  ;
            endcase
          end else if (state_d == ST_RUN) begin
            presc_q <= '0;
          end
        end
        ST_RUN: begin
          if (!ev_run) begin
            presc_q <= pre_wrap ? '0 : presc_q + PW'(1);
            if (tick) begin
              ss_q <= ss_dn;
              mm_q <= mm_dn;
              hh_q <= hh_dn;
              if (dn_zero) begin
                done_q     <= 1'b1;
                alarm_q    <= 1'b1;
                blk_done_q <= 1'b1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (!ev_run && ev_stc) sel_q <= SEL_SEC;
        end
        ST_DONE: begin
          presc_q <= pre_wrap ? '0 : presc_q + PW'(1);
          if (pre_wrap) blk_done_q <= ~blk_done_q;
          if (ev_run) begin
            alarm_q <= 1'b0;
            sel_q   <= SEL_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hh    = hh_q;
  assign bus.mm    = mm_q;
  assign bus.ss    = ss_q;
  assign bus.sel   = sel_q;
  assign bus.state = state_q;
  assign bus.blk   = blk;
  assign bus.done  = done_q;
  assign bus.alarm = alarm_q;
endmodule
